wb_sequencer: RTL and testbench

WB_SEQUENCER -- requirements
Module: wb_sequencer

---
 rtl/wb_sequencer_pkg.sv | 47 ++++
 rtl/wb_sequencer_if.sv | 29 ++
 rtl/wb_sequencer.sv | 118 +++++++++++
 tb/tb_wb_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sequencer_pkg.sv
// Shared ALU/writeback definitions: opcode map, sequencer state encoding and
// the captured-result payload type.
package wb_sequencer_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned RESULT_W = 32;
  localparam int unsigned HALF_W   = 16;
  localparam int unsigned COUNT_W  = 16;

  // ALU opcode map (instruction bits 31:26)
  localparam logic [OP_W-1:0] ALU_OP_NOP   = 6'b000000;
  localparam logic [OP_W-1:0] ALU_OP_ADD   = 6'b000001;
  localparam logic [OP_W-1:0] ALU_OP_SUB   = 6'b000010;
  localparam logic [OP_W-1:0] ALU_OP_STORE = 6'b000011;
  localparam logic [OP_W-1:0] ALU_OP_LOAD  = 6'b000100;
  localparam logic [OP_W-1:0] ALU_OP_AND   = 6'b000101;
  localparam logic [OP_W-1:0] ALU_OP_OR    = 6'b000110;
  localparam logic [OP_W-1:0] ALU_OP_MUL   = 6'b000111;
  localparam logic [OP_W-1:0] ALU_OP_XOR   = 6'b001000;
  localparam logic [OP_W-1:0] ALU_OP_SLL   = 6'b001001;
  localparam logic [OP_W-1:0] ALU_OP_SRL   = 6'b001010;
  localparam logic [OP_W-1:0] ALU_OP_SRA   = 6'b001011;
  localparam logic [OP_W-1:0] ALU_OP_SLT   = 6'b001100;
  localparam logic [OP_W-1:0] ALU_OP_SLTU  = 6'b001101;
  localparam logic [OP_W-1:0] ALU_OP_LUI   = 6'b001110;
  localparam logic [OP_W-1:0] ALU_OP_NOT   = 6'b001111;
  localparam logic [OP_W-1:0] ALU_OP_MAX   = 6'b010000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [RESULT_W-1:0] result;
  } alu_result_t;

  // True when an opcode produces at least one register write.
  function automatic logic op_writes(input logic [OP_W-1:0] op,
                                     input logic [OP_W-1:0] op_store,
                                     input logic [OP_W-1:0] op_max);
    return (op <= op_max) && (op != op_store);
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// ALU-result handshake plus register-file write port, seen from the ALU side
// (master) and the writeback sequencer (slave).
interface wb_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) ();
  import wb_sequencer_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_op;
  logic [RESULT_W-1:0] in_result;
  logic [ADDR_W-1:0]   in_rdst1;
  logic [ADDR_W-1:0]   in_rdst2;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_addr;
  logic [DATA_W-1:0]   rf_wdata;

  modport master (
    output in_valid, in_op, in_result, in_rdst1, in_rdst2,
    input  in_ready, rf_we, rf_addr, rf_wdata
  );

  modport slave (
    input  in_valid, in_op, in_result, in_rdst1, in_rdst2,
    output in_ready, rf_we, rf_addr, rf_wdata
  );

endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: turns accepted ALU results into one or two register-file
// writes (two for MUL), one write per cycle, with sticky illegal-opcode flag.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int unsigned     DATA_W   = 16,
  parameter int unsigned     ADDR_W   = 5,
  parameter logic [OP_W-1:0] OP_MUL   = ALU_OP_MUL,
  parameter logic [OP_W-1:0] OP_STORE = ALU_OP_STORE,
  parameter logic [OP_W-1:0] OP_MAX   = ALU_OP_MAX
) (
  input  logic               clk,
  input  logic               reset,
  wb_sequencer_if.slave      bus,
  output logic               busy,
  output logic               illegal,
  output logic [COUNT_W-1:0] wb_count
);

  seq_state_t        state, state_nxt;
  alu_result_t       hold, hold_nxt;
  logic [ADDR_W-1:0] hold_rdst1, hold_rdst1_nxt;
  logic [ADDR_W-1:0] hold_rdst2, hold_rdst2_nxt;
  logic              illegal_nxt;
  logic              ready_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              handshake_c;
  logic              writing_c;

  assign handshake_c = bus.in_valid && bus.in_ready;
  assign writing_c   = handshake_c && op_writes(bus.in_op, OP_STORE, OP_MAX);

  // Next state, holding register and the write that the next cycle performs.
  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    hold_rdst1_nxt = hold_rdst1;
    hold_rdst2_nxt = hold_rdst2;
    illegal_nxt    = illegal;
    ready_nxt      = 1'b1;
    we_nxt         = 1'b0;
    addr_nxt       = '0;
    wdata_nxt      = '0;

    if (handshake_c) begin
      hold_nxt.op     = bus.in_op;
      hold_nxt.result = bus.in_result;
      hold_rdst1_nxt  = bus.in_rdst1;
      hold_rdst2_nxt  = bus.in_rdst2;
      if (bus.in_op > OP_MAX) begin
        illegal_nxt = 1'b1;
      end
    end

    unique case (state)
      IDLE:    state_nxt = writing_c ? WR_LO : IDLE;
      WR_LO: begin
        if (hold.op == OP_MUL) begin
          state_nxt = WR_HI;
        end else begin
          state_nxt = writing_c ? WR_LO : IDLE;
        end
      end
      WR_HI:   state_nxt = writing_c ? WR_LO : IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    unique case (state_nxt)
      WR_LO: begin
        we_nxt    = 1'b1;
        addr_nxt  = hold_rdst1_nxt;
        wdata_nxt = DATA_W'(hold_nxt.result[HALF_W-1:0]);
        ready_nxt = (hold_nxt.op != OP_MUL);
      end
      WR_HI: begin
        we_nxt    = 1'b1;
        addr_nxt  = hold_rdst2_nxt;
        wdata_nxt = DATA_W'(hold_nxt.result[RESULT_W-1:HALF_W]);
      end
      default: begin
        we_nxt    = 1'b0;
      end
    endcase
  end

  // State, holding register and registered outputs; reset drops pending writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold         <= '0;
      hold_rdst1   <= '0;
      hold_rdst2   <= '0;
      bus.in_ready <= 1'b1;
      bus.rf_we    <= 1'b0;
      bus.rf_addr  <= '0;
      bus.rf_wdata <= '0;
      busy         <= 1'b0;
      illegal      <= 1'b0;
      wb_count     <= '0;
    end else begin
      state        <= state_nxt;
      hold         <= hold_nxt;
      hold_rdst1   <= hold_rdst1_nxt;
      hold_rdst2   <= hold_rdst2_nxt;
      bus.in_ready <= ready_nxt;
      bus.rf_we    <= we_nxt;
      bus.rf_addr  <= addr_nxt;
      bus.rf_wdata <= wdata_nxt;
      busy         <= (state_nxt != IDLE);
      illegal      <= illegal_nxt;
      wb_count     <= wb_count + COUNT_W'(we_nxt);
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed vectors, a queue-of-pending-writes model
// compared every cycle, and literal expectations at key points.
module tb_wb_sequencer;
  import wb_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        illegal;
  logic [15:0] wb_count;

  wb_sequencer_if bus ();

  wb_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .illegal  (illegal),
    .wb_count (wb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         pend[$];
  logic        m_illegal = 1'b0;
  logic [15:0] m_count = 16'd0;
  bit          model_on = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  // Model: pending writes drain one per cycle; the head is the write in flight.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      pend.delete();
      m_illegal = 1'b0;
      m_count   = 16'd0;
      model_on  = 1'b1;
    end else if (model_on) begin
      bit take;
      take = bus.in_valid && (pend.size() <= 1);
      if (pend.size() != 0) void'(pend.pop_front());
      if (take) begin
        if (bus.in_op > ALU_OP_MAX) begin
          m_illegal = 1'b1;
        end else if (bus.in_op != ALU_OP_STORE) begin
          pend.push_back('{addr: bus.in_rdst1, data: bus.in_result[15:0]});
          if (bus.in_op == ALU_OP_MUL)
            pend.push_back('{addr: bus.in_rdst2, data: bus.in_result[31:16]});
        end
      end
      if (pend.size() != 0) m_count = m_count + 16'd1;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      logic        e_we;
      logic [4:0]  e_addr;
      logic [15:0] e_data;
      logic        e_ready;
      e_we    = (pend.size() != 0);
      e_addr  = e_we ? pend[0].addr : 5'd0;
      e_data  = e_we ? pend[0].data : 16'd0;
      e_ready = (pend.size() <= 1);
      vectors++;
      if (bus.rf_we !== e_we || bus.rf_addr !== e_addr || bus.rf_wdata !== e_data ||
          bus.in_ready !== e_ready || busy !== e_we || illegal !== m_illegal ||
          wb_count !== m_count) begin
        miscompares++;
        $display("FAIL model t=%0t: got we=%b addr=%0d data=%h rdy=%b busy=%b ill=%b cnt=%h, expected we=%b addr=%0d data=%h rdy=%b busy=%b ill=%b cnt=%h",
                 $time, bus.rf_we, bus.rf_addr, bus.rf_wdata, bus.in_ready, busy, illegal, wb_count,
                 e_we, e_addr, e_data, e_ready, e_we, m_illegal, m_count);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one result and returns just after the edge it was accepted on.
  task automatic send(input logic [5:0] op, input logic [31:0] res,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_result = res;
    bus.in_rdst1  = r1;
    bus.in_rdst2  = r2;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_result = '0;
    bus.in_rdst1  = '0;
    bus.in_rdst2  = '0;
    step();
    step();
    reset = 1'b0;

    @(negedge clk);
    check("reset_ready", 32'(bus.in_ready), 32'd1);
    check("reset_we",    32'(bus.rf_we),    32'd0);
    check("reset_busy",  32'(busy),         32'd0);
    check("reset_count", 32'(wb_count),     32'd0);
    step();

    send(ALU_OP_ADD, 32'h0000_1234, 5'd3, 5'd0);
    @(negedge clk);
    check("add_we",    32'(bus.rf_we),    32'd1);
    check("add_addr",  32'(bus.rf_addr),  32'd3);
    check("add_data",  32'(bus.rf_wdata), 32'h1234);
    check("add_count", 32'(wb_count),     32'd1);
    step();

    send(ALU_OP_MUL, 32'hABCD_5678, 5'd4, 5'd5);
    @(negedge clk);
    check("mul_lo_addr",  32'(bus.rf_addr),  32'd4);
    check("mul_lo_data",  32'(bus.rf_wdata), 32'h5678);
    check("mul_lo_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("mul_hi_addr",  32'(bus.rf_addr),  32'd5);
    check("mul_hi_data",  32'(bus.rf_wdata), 32'hABCD);
    check("mul_hi_ready", 32'(bus.in_ready), 32'd1);
    check("mul_count",    32'(wb_count),     32'd3);
    step();

    send(ALU_OP_ADD, 32'h0000_0011, 5'd1, 5'd0);
    send(ALU_OP_SUB, 32'h0000_0022, 5'd2, 5'd0);
    send(ALU_OP_ADD, 32'h0000_0033, 5'd3, 5'd0);
    @(negedge clk);
    check("b2b_addr",  32'(bus.rf_addr),  32'd3);
    check("b2b_data",  32'(bus.rf_wdata), 32'h0033);
    check("b2b_count", 32'(wb_count),     32'd6);
    step();

    send(ALU_OP_MUL, 32'h0102_0304, 5'd7, 5'd7);
    @(negedge clk);
    check("same_lo_data", 32'(bus.rf_wdata), 32'h0304);
    @(negedge clk);
    check("same_hi_addr", 32'(bus.rf_addr),  32'd7);
    check("same_hi_data", 32'(bus.rf_wdata), 32'h0102);
    step();

    send(ALU_OP_MAX, 32'h0000_9999, 5'd9, 5'd0);
    @(negedge clk);
    check("opmax_we",   32'(bus.rf_we), 32'd1);
    check("opmax_addr", 32'(bus.rf_addr), 32'd9);
    step();

    send(ALU_OP_STORE, 32'hFFFF_FFFF, 5'd10, 5'd10);
    send(6'b111111,    32'hFFFF_FFFF, 5'd11, 5'd11);
    @(negedge clk);
    check("ill_we",      32'(bus.rf_we), 32'd0);
    check("ill_flag",    32'(illegal),   32'd1);
    check("ill_count",   32'(wb_count),  32'd9);
    step();
    send(6'b010001, 32'h0000_7777, 5'd12, 5'd0);
    @(negedge clk);
    check("above_max_we", 32'(bus.rf_we), 32'd0);
    step();
    send(ALU_OP_ADD, 32'h0000_5555, 5'd13, 5'd0);
    @(negedge clk);
    check("ill_sticky", 32'(illegal),  32'd1);
    check("post_count", 32'(wb_count), 32'd10);
    step();

    send(ALU_OP_MUL, 32'hDEAD_BEEF, 5'd14, 5'd15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_we",    32'(bus.rf_we),    32'd0);
    check("rst_mid_addr",  32'(bus.rf_addr),  32'd0);
    check("rst_mid_data",  32'(bus.rf_wdata), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_ill",   32'(illegal),      32'd0);
    check("rst_mid_count", 32'(wb_count),     32'd0);
    @(negedge clk);
    check("rst_no_hi_we",  32'(bus.rf_we),    32'd0);
    step();

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = ALU_OP_ADD;
    bus.in_result = 32'h0000_4321;
    bus.in_rdst1  = 5'd17;
    step();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_hs_we", 32'(bus.rf_we), 32'd0);
    step();

    for (int i = 0; i < 65535; i++) send(ALU_OP_ADD, 32'(i), 5'(i), 5'd0);
    @(negedge clk);
    check("count_ffff", 32'(wb_count), 32'h0000_FFFF);
    step();
    send(ALU_OP_ADD, 32'h0000_0001, 5'd1, 5'd0);
    @(negedge clk);
    check("count_wrap", 32'(wb_count), 32'd0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
